// File: rtl/rr_port_arbiter4.sv
// rr_port_arbiter4: four-lane round-robin arbiter sharing one downstream output port.
//
// Both sides use a level-sensitive four-phase req/ack handshake. A grant is issued
// only from IDLE. The lane is chosen from in_req & en_mask, searching upward from the
// priority pointer. The granted lane's data is latched into out_data and held for the
// whole transaction. After the transaction the pointer moves to the lane after the one
// just served, so a lane that keeps requesting waits for at most three other grants.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_req[3:0]        per-lane request
//   in_data[4*n-1:0]   lane i data in bits [i*n +: n]
//   in_ack[3:0]        per-lane acknowledge; only the granted lane's bit can be set
//   en_mask[3:0]       lane enable, sampled only when choosing a grant
//   out_req, out_ack   downstream handshake
//   out_data[n-1:0]    registered data of the granted lane
//   grant_idx[1:0]     lane currently or most recently granted
//   busy               FSM is not idle
//   stall              wait on out_ack has lasted TIMEOUT cycles (status only)
module rr_port_arbiter4 #(
    parameter int unsigned n       = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_req,
    input  logic [4*n-1:0] in_data,
    output logic [3:0]     in_ack,
    input  logic [3:0]     en_mask,
    output logic           out_req,
    output logic [n-1:0]   out_data,
    input  logic           out_ack,
    output logic [1:0]     grant_idx,
    output logic           busy,
    output logic           stall
);

    typedef enum logic [1:0] {StIdle, StReq, StAcked, StRel} state_e;

    state_e      state_q;
    logic [1:0]  ptr_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_inc;
    logic [3:0]  elig;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic [1:0]  cand;

    assign elig    = in_req & en_mask;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign busy    = (state_q != StIdle);
    assign stall   = (cnt_q >= 16'(TIMEOUT));

    // Scan from the farthest candidate back toward ptr so the nearest hit wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (elig[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            cnt_q     <= 16'd0;
            in_ack    <= 4'd0;
            out_req   <= 1'b0;
            out_data  <= '0;
            grant_idx <= 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sel_valid) begin
                        grant_idx <= sel_idx;
                        out_data  <= in_data[sel_idx*n +: n];
                        out_req   <= 1'b1;
                        cnt_q     <= 16'd0;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (out_ack) begin
                        in_ack[grant_idx] <= 1'b1;
                        cnt_q             <= 16'd0;
                        state_q           <= StAcked;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StAcked: begin
                    // If the lane already dropped its request early, this exits at once.
                    if (!in_req[grant_idx]) begin
                        out_req <= 1'b0;
                        cnt_q   <= 16'd0;
                        state_q <= StRel;
                    end
                end
                StRel: begin
                    if (!out_ack) begin
                        in_ack[grant_idx] <= 1'b0;
                        ptr_q             <= grant_idx + 2'd1;
                        cnt_q             <= 16'd0;
                        state_q           <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_port_arbiter4.sv
// Self-checking bench for rr_port_arbiter4.
// Expected grants (lane, data) are pushed into a queue by the stimulus. A monitor pops
// one entry on every rising edge of out_req and compares. Lane requesters and the
// downstream responder are autonomous processes that complete handshakes with zero latency.
module tb_rr_port_arbiter4;

    localparam int unsigned N  = 32;
    localparam int unsigned TO = 10;

    typedef struct {
        logic [1:0]   idx;
        logic [N-1:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     in_req = 4'd0;
    logic [4*N-1:0] in_data;
    logic [3:0]     in_ack;
    logic [3:0]     en_mask = 4'hF;
    logic           out_req;
    logic [N-1:0]   out_data;
    logic           out_ack = 1'b0;
    logic [1:0]     grant_idx;
    logic           busy;
    logic           stall;

    logic [N-1:0] lane_data [4];
    int           issued [4] = '{default: 0};
    int           raised [4] = '{default: 0};
    logic         hold = 1'b0;
    logic         flush = 1'b0;
    logic         auto_ack = 1'b1;
    logic         prev_req = 1'b0;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    assign in_data = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

    rr_port_arbiter4 #(
        .n       (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .en_mask   (en_mask),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .grant_idx (grant_idx),
        .busy      (busy),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Lane requesters: raise once per issued request, drop after ack unless held.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush) begin
                in_req[i] = 1'b0;
                raised[i] = issued[i];
            end else if (in_req[i] && in_ack[i] && !hold) begin
                in_req[i] = 1'b0;
            end else if (!in_req[i] && !in_ack[i] && (issued[i] > raised[i])) begin
                in_req[i] = 1'b1;
                raised[i]++;
            end
        end
    end

    // Downstream responder: follows out_req with zero latency when enabled.
    always @(negedge clk) begin
        if (auto_ack) out_ack = out_req;
        else          out_ack = 1'b0;
    end

    // Monitor: invariants every cycle, scoreboard on each new grant.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            check("ack_only_granted", {60'd0, in_ack & ~(4'b0001 << grant_idx)}, 64'd0);
            if (out_req && !prev_req) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got lane %0d data %0h, none expected",
                             grant_idx, out_data);
                end else begin
                    e = sb.pop_front();
                    check("grant_idx", {62'd0, grant_idx}, {62'd0, e.idx});
                    check("grant_data", {32'd0, out_data}, {32'd0, e.data});
                end
            end
        end
        prev_req = out_req;
    end

    task automatic expect_grant(input logic [1:0] idx, input logic [N-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b1;
        hold     = 1'b0;
        auto_ack = 1'b1;
        en_mask  = 4'hF;
        sb.delete();
        @(posedge clk);
        #1;
        check("reset_outputs", {22'd0, in_ack, out_req, out_data, grant_idx, busy, stall},
              64'd0);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < 300) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        total++;
        if (sb.size() != 0 || busy) begin
            bad++;
            $display("FAIL %s_drain: got %0d grants pending busy=%0b, required 0 and 0",
                     name, sb.size(), busy);
        end
    endtask

    task automatic wait_out_req(input string name);
        int cyc = 0;
        while (!out_req && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check({name, "_out_req_wait"}, {63'd0, out_req}, 64'd1);
    endtask

    task automatic wait_in_ack(input string name, input int lane);
        int cyc = 0;
        while (!in_ack[lane] && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check({name, "_in_ack_wait"}, {63'd0, in_ack[lane]}, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) lane_data[i] = 32'hA0A0_0000 | 32'(i);
        @(posedge clk);
        #2;

        // Single request on lane 2.
        do_reset();
        lane_data[2] = 32'hCAFE_0002;
        expect_grant(2'd2, 32'hCAFE_0002);
        issued[2]++;
        @(posedge clk);
        #1;
        check("t1_out_req_latency", {63'd0, out_req}, 64'd1);
        check("t1_busy", {63'd0, busy}, 64'd1);
        #1;
        drain("t1");
        check("t1_in_ack_idle", {60'd0, in_ack}, 64'd0);
        check("t1_grant_idx_held", {62'd0, grant_idx}, 64'd2);
        // Pointer is now 3: lane 3 beats lane 0.
        expect_grant(2'd3, lane_data[3]);
        expect_grant(2'd0, lane_data[0]);
        issued[0]++;
        issued[3]++;
        drain("t1_ptr");

        // Round robin with all lanes re-requesting.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) expect_grant(2'(i), lane_data[i]);
        for (int i = 0; i < 4; i++) issued[i] += 2;
        drain("rr");

        // Mask 1010: only lanes 1 and 3, then re-enable the rest.
        do_reset();
        en_mask = 4'b1010;
        expect_grant(2'd1, lane_data[1]);
        expect_grant(2'd3, lane_data[3]);
        expect_grant(2'd1, lane_data[1]);
        expect_grant(2'd3, lane_data[3]);
        issued[0] += 1;
        issued[1] += 2;
        issued[2] += 1;
        issued[3] += 2;
        drain("mask");
        en_mask = 4'hF;
        expect_grant(2'd0, lane_data[0]);
        expect_grant(2'd2, lane_data[2]);
        drain("mask_restore");

        // Clearing a lane's enable mid-transaction does not abort it.
        do_reset();
        auto_ack = 1'b0;
        expect_grant(2'd1, lane_data[1]);
        issued[1] += 2;
        issued[3] += 1;
        wait_out_req("mchg");
        en_mask  = 4'b1101;
        auto_ack = 1'b1;
        expect_grant(2'd3, lane_data[3]);
        drain("mchg");
        en_mask = 4'hF;
        expect_grant(2'd1, lane_data[1]);
        drain("mchg_restore");

        // Stall after TIMEOUT waiting cycles, cleared when out_ack arrives.
        do_reset();
        auto_ack = 1'b0;
        lane_data[0] = 32'h5747_0000;
        expect_grant(2'd0, 32'h5747_0000);
        issued[0]++;
        wait_out_req("stall");
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_wait%0d", k), {63'd0, stall}, {63'd0, (k >= 10)});
        end
        check("stall_out_req_held", {63'd0, out_req}, 64'd1);
        #1;
        auto_ack = 1'b1;
        @(posedge clk);
        #1;
        check("stall_cleared", {63'd0, stall}, 64'd0);
        check("stall_in_ack", {60'd0, in_ack}, 64'd1);
        #1;
        drain("stall");

        // Reset while in ACKED with lane 0 pending.
        do_reset();
        expect_grant(2'd0, lane_data[0]);
        issued[0]++;
        drain("mrst_pre");
        hold = 1'b1;
        expect_grant(2'd1, lane_data[1]);
        issued[1]++;
        wait_in_ack("mrst", 1);
        issued[0]++;
        @(posedge clk);
        #2;
        check("mrst_in_req", {60'd0, in_req}, 64'h3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_outputs", {22'd0, in_ack, out_req, out_data, grant_idx, busy, stall}, 64'd0);
        #1;
        rst  = 1'b0;
        hold = 1'b0;
        expect_grant(2'd0, lane_data[0]);
        expect_grant(2'd1, lane_data[1]);
        drain("mrst");

        // Data stability across a transaction.
        do_reset();
        lane_data[0] = 32'hD000_0001;
        hold = 1'b1;
        expect_grant(2'd0, 32'hD000_0001);
        issued[0]++;
        wait_in_ack("dstab", 0);
        lane_data[0] = 32'hD000_0002;
        @(posedge clk);
        #1;
        check("dstab_hold1", {32'd0, out_data}, 64'hD000_0001);
        @(posedge clk);
        #1;
        check("dstab_hold2", {32'd0, out_data}, 64'hD000_0001);
        #1;
        hold = 1'b0;
        drain("dstab");
        check("dstab_idle", {32'd0, out_data}, 64'hD000_0001);
        expect_grant(2'd0, 32'hD000_0002);
        issued[0]++;
        drain("dstab2");
        check("dstab_new", {32'd0, out_data}, 64'hD000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/rr_port_arbiter4.md
Name: rr_port_arbiter4

Overview:
- Clocked four-input round-robin arbiter sharing one router output port (for example the processor output) between up to four input channels.
- Replaces the free-running arbiter on that path with a deterministic, fair scheduler that can be verified.
- Each side uses a level-sensitive four-phase req/ack handshake.
- Output data is registered and held stable for the whole transaction.

Parameters:
- n, 32: data bus width per channel.
- TIMEOUT, 255: cycles spent waiting on out_ack before stall asserts. Range 1..65535.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_req  in  4  per-lane request; bit i belongs to lane i.
- in_data  in  4*n  lane i occupies bits [i*n+n-1 : i*n]; stable while in_req[i]=1.
- in_ack  out  4  per-lane acknowledge.
- en_mask  in  4  lane enable; a lane with a 0 bit is never granted.
- out_req  out  1  request to the downstream port.
- out_data  out  n  registered data of the granted lane.
- out_ack  in  1  acknowledge from downstream.
- grant_idx  out  2  lane currently or last granted.
- busy  out  1  1 whenever the FSM is not in IDLE.
- stall  out  1  1 while the out_ack wait has reached TIMEOUT.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge), effective at that edge even mid-transaction:
  - in_ack=0, out_req=0, out_data=0, grant_idx=0, busy=0, stall=0.
  - Priority pointer ptr=0, stall counter=0, state=IDLE.
- Eligible lanes: elig = in_req & en_mask, sampled only in IDLE.
- Lane selection: the first set bit of elig searched in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- State IDLE:
  - If elig is nonzero, register g = selected lane, out_data <= lane g data, out_req <= 1, grant_idx <= g, then go to REQ.
  - Latency: in_req sampled at edge t gives out_req=1 after edge t.
  - If elig is zero, remain in IDLE.
- State REQ (waiting for out_ack rising): when out_ack=1, in_ack[g] <= 1 and go to ACKED.
- State ACKED (waiting for the requester to drop): when in_req[g]=0, out_req <= 0 and go to REL.
- State REL (waiting for out_ack falling): when out_ack=0, in_ack[g] <= 0, ptr <= (g+1) mod 4, then go to IDLE.
- Minimum transaction length is 4 cycles, with zero-latency responders on both sides.
- A new grant is possible on the edge after returning to IDLE.
- Only in_ack[g] may ever be 1; the other in_ack bits stay 0 at all times.
- out_data changes only on the IDLE to REQ transition.
- Changes to en_mask, or new requests, take effect only in IDLE. The current transaction always completes.
- Lane g dropping in_req before in_ack[g] (protocol violation): ignored. The FSM still waits for out_ack and then proceeds; ACKED exits on the next cycle.
- Stall counter:
  - 16 bits; increments each cycle in REQ or REL while the awaited out_ack level is absent.
  - Clears on every state change.
  - Saturates at 65535.
  - stall is combinational (counter >= TIMEOUT) and is meaningful only in REQ or REL.
  - stall is status only and does not abort the transaction.
- Fairness: a continuously requesting, enabled lane is granted within 3 foreign grants.
- Simultaneous events:
  - All four lanes requesting with ptr=0 grants lanes 0, 1, 2, 3, 0, and so on.
  - out_ack and in_req[g] changing in the same cycle are each handled by their own state in sequence; there are no skipped states.

Test Plan:
- Reset then a single request: in_req=4'b0100, data2=32'hCAFE0002, zero-latency downstream -> out_req rises 1 cycle later, out_data=32'hCAFE0002, grant_idx=2, in_ack=4'b0100 after out_ack; ptr=3 at the end; only in_ack[2] toggles.
- Round robin: all lanes hold in_req=1 and re-request immediately -> grant_idx sequence 0, 1, 2, 3, 0; no lane granted twice before the others.
- Mask: in_req=4'b1111, en_mask=4'b1010 -> only grants 1, 3, 1, 3. Clearing en_mask[1] during lane 1's REQ -> lane 1 still completes; the next grant is 3.
- Stall: TIMEOUT=10, downstream holds out_ack=0 -> stall=1 from the 10th waiting cycle; out_req stays 1. Raising out_ack -> stall=0 and the transaction completes normally.
- Reset mid-transaction: assert rst in ACKED -> next cycle in_ack=0, out_req=0, out_data=0, busy=0, ptr=0. A pending request on lane 0 is then granted first.
- Data stability: lane 0 changes in_data after its grant -> out_data keeps the value latched at grant until the next IDLE to REQ transition.
